// File: rtl/seg7_stopwatch.sv
// Single-digit stopwatch: synchronized start/stop and clear buttons, a prescaled 0..MAX_COUNT
// counter with wrap pulse, and a registered seven-segment decode of the count.
module seg7_stopwatch #(
    parameter int unsigned CLK_DIV   = 10000000,
    parameter int unsigned MAX_COUNT = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       load_en,
    input  logic [3:0] load_val,
    output logic [6:0] segments,
    output logic       dp,
    output logic [3:0] count,
    output logic       running,
    output logic       wrap
);

    localparam int unsigned    PsW    = $clog2(CLK_DIV);
    localparam logic [PsW-1:0] PsLast = PsW'(CLK_DIV - 1);
    localparam logic [3:0]     MaxCnt = 4'(MAX_COUNT);

    typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

    state_e         state_q;
    logic [PsW-1:0] presc_q;
    logic [3:0]     count_q;
    logic           start_s1_q, start_s2_q, start_prev_q;
    logic           clear_s1_q, clear_s2_q, clear_prev_q;
    logic           start_evt, clear_evt;

    assign start_evt = start_s2_q & ~start_prev_q;
    assign clear_evt = clear_s2_q & ~clear_prev_q;
    assign count     = count_q;
    assign running   = (state_q == StRun);

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0: decode = 7'h3F;
            4'h1: decode = 7'h06;
            4'h2: decode = 7'h5B;
            4'h3: decode = 7'h4F;
            4'h4: decode = 7'h66;
            4'h5: decode = 7'h6D;
            4'h6: decode = 7'h7D;
            4'h7: decode = 7'h07;
            4'h8: decode = 7'h7F;
            4'h9: decode = 7'h6F;
            4'hA: decode = 7'h77;
            4'hB: decode = 7'h7C;
            4'hC: decode = 7'h39;
            4'hD: decode = 7'h5E;
            4'hE: decode = 7'h79;
            default: decode = 7'h71;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            presc_q      <= '0;
            count_q      <= 4'd0;
            start_s1_q   <= 1'b0;
            start_s2_q   <= 1'b0;
            start_prev_q <= 1'b0;
            clear_s1_q   <= 1'b0;
            clear_s2_q   <= 1'b0;
            clear_prev_q <= 1'b0;
            segments     <= 7'h3F;
            dp           <= 1'b0;
            wrap         <= 1'b0;
        end else if (ena) begin
            start_s1_q   <= btn_start;
            start_s2_q   <= start_s1_q;
            start_prev_q <= start_s2_q;
            clear_s1_q   <= btn_clear;
            clear_s2_q   <= clear_s1_q;
            clear_prev_q <= clear_s2_q;
            segments     <= decode(count_q);
            dp           <= (state_q == StPause);
            wrap         <= 1'b0;
            // Clear outranks start, so a coincident start event is simply dropped.
            if (clear_evt) begin
                state_q <= StIdle;
                presc_q <= '0;
                count_q <= 4'd0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start_evt) begin
                            state_q <= StRun;
                        end else if (load_en) begin
                            count_q <= (load_val > MaxCnt) ? MaxCnt : load_val;
                        end
                    end
                    StRun: begin
                        if (presc_q == PsLast) begin
                            presc_q <= '0;
                            if (count_q >= MaxCnt) begin
                                count_q <= 4'd0;
                                wrap    <= 1'b1;
                            end else begin
                                count_q <= count_q + 4'd1;
                            end
                        end else begin
                            presc_q <= presc_q + 1'b1;
                        end
                        if (start_evt) state_q <= StPause;
                    end
                    StPause: begin
                        if (start_evt) state_q <= StRun;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule
